// File: rtl/uart_rx.sv
// ---- uart_rx : 8N1 async serial receiver, mid-bit sampling, one-byte holding register ----
// ---- Rev 1.0  : initial release                                                           ----
`default_nettype none

module uart_rx #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 19200
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       rx_n,
  output logic [7:0] rx_data,
  output logic       rx_ready_n,
  input  logic       rx_r_n,
  output logic       rx_ovr_n,
  output logic       rx_ferr_n
);

  localparam int BIT_TICKS  = CLK_HZ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TW         = $clog2(BIT_TICKS + 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nx;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nx;
  logic          tick;
  logic          commit;
  logic          ferr;

  // Two-flop synchronizer; reset to the idle line level
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_n;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (timer == '0);

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
    end
  end

  // Timer counts down to zero; the sample is taken on the zero cycle and the timer reloads
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    commit     = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          timer_nx = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          timer_nx = timer - TW'(1);
        end else if (rx_s) begin
          state_nx = IDLE;
        end else begin
          state_nx   = DATA;
          timer_nx   = BIT_LOAD;
          bit_cnt_nx = 3'd0;
        end
      end
      DATA: begin
        if (!tick) begin
          timer_nx = timer - TW'(1);
        end else begin
          shreg_nx   = {rx_s, shreg[7:1]};
          timer_nx   = BIT_LOAD;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (!tick) begin
          timer_nx = timer - TW'(1);
        end else if (rx_s) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else begin
          ferr     = 1'b1;
          state_nx = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Host side: a commit beats a simultaneous read, and a read then clears any overrun
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= 8'h00;
      rx_ready_n <= 1'b1;
      rx_ovr_n   <= 1'b1;
      rx_ferr_n  <= 1'b1;
    end else begin
      rx_ferr_n <= ~ferr;
      if (commit) begin
        rx_data    <= shreg;
        rx_ready_n <= 1'b0;
        if (!rx_r_n) begin
          rx_ovr_n <= 1'b1;
        end else if (!rx_ready_n) begin
          rx_ovr_n <= 1'b0;
        end
      end else if (!rx_r_n) begin
        rx_ready_n <= 1'b1;
        rx_ovr_n   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---- tb_uart_rx : scoreboard bench for uart_rx with directed scenarios and random frames ----
// ---- Rev 1.0                                                                              ----
`default_nettype none

module tb_uart_rx;

  localparam int CLK_HZ = 3200;
  localparam int BAUD   = 100;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_n = 1'b1;
  logic       main_r_n = 1'b1;
  logic       auto_r_n = 1'b1;
  logic       rx_r_n;
  logic [7:0] rx_data;
  logic       rx_ready_n;
  logic       rx_ovr_n;
  logic       rx_ferr_n;

  assign rx_r_n = main_r_n & auto_r_n;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_48    (clk),
    .rst_n     (rst_n),
    .rx_n      (rx_n),
    .rx_data   (rx_data),
    .rx_ready_n(rx_ready_n),
    .rx_r_n    (rx_r_n),
    .rx_ovr_n  (rx_ovr_n),
    .rx_ferr_n (rx_ferr_n)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ovr_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ferr_count = 0;
  int   cyc = 0;
  int   last_event_cyc = 0;
  bit   auto_read = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: a new byte is visible when ready falls, or the data changes while ready stays low
  logic       prev_ready = 1'b1;
  logic [7:0] prev_data = 8'h00;
  exp_t       exp_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_ready_n === 1'b0 && (prev_ready !== 1'b0 || rx_data !== prev_data)) begin
        last_event_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          exp_e = sb.pop_front();
          check("rx_data", rx_data, exp_e.data);
          check("rx_ovr_n_at_commit", rx_ovr_n, exp_e.ovr_n);
        end
      end
      if (rx_ferr_n === 1'b0) ferr_count++;
    end
    prev_ready = rx_ready_n;
    prev_data  = rx_data;
  end

  // Random-phase host reader
  initial begin
    forever begin
      @(negedge clk);
      if (auto_read && rx_ready_n === 1'b0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1 auto_r_n = 1'b0;
        @(posedge clk);
        #1 auto_r_n = 1'b1;
      end
    end
  end

  task automatic send_bit(input logic b, input int clks);
    rx_n = b;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clks);
    send_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) send_bit(d[i], clks);
    send_bit(stop, clks);
  endtask

  task automatic idle(input int n);
    rx_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse();
    main_r_n = 1'b0;
    @(posedge clk);
    #1 main_r_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_ready_n"}, rx_ready_n, 1'b1);
    check({tag, "_rx_ovr_n"}, rx_ovr_n, 1'b1);
    check({tag, "_rx_ferr_n"}, rx_ferr_n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int t_start;
    int f0;
    int exp_ferr;
    byte unsigned b;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(5);

    // Single frame 0x55 with latency window
    sb.push_back({8'h55, 1'b1});
    t_start = cyc;
    send_frame(8'h55, 1'b1, BIT);
    idle(BIT);
    check("latency_in_window",
          ((last_event_cyc - t_start) >= HALF + 9*BIT + 1) &&
          ((last_event_cyc - t_start) <= HALF + 9*BIT + 5), 1'b1);
    check("rx_ready_n_55", rx_ready_n, 1'b0);
    check("ferr_none_55", ferr_count, 0);
    read_pulse();
    check("rx_ready_n_after_read", rx_ready_n, 1'b1);
    check("rx_data_held_after_read", rx_data, 8'h55);

    // Short glitch on idle line, then a real frame
    rx_n = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    idle(3*BIT);
    check("glitch_no_ready", rx_ready_n, 1'b1);
    check("glitch_no_ferr", ferr_count, 0);
    sb.push_back({8'hA3, 1'b1});
    send_frame(8'hA3, 1'b1, BIT);
    idle(BIT);
    read_pulse();

    // Back-to-back with no read: overrun
    sb.push_back({8'h01, 1'b1});
    sb.push_back({8'h80, 1'b0});
    send_frame(8'h01, 1'b1, BIT);
    send_frame(8'h80, 1'b1, BIT);
    idle(BIT);
    check("ovr_rx_data", rx_data, 8'h80);
    check("ovr_rx_ovr_n", rx_ovr_n, 1'b0);
    check("ovr_rx_ready_n", rx_ready_n, 1'b0);
    read_pulse();
    check("ovr_clear_ready", rx_ready_n, 1'b1);
    check("ovr_clear_ovr", rx_ovr_n, 1'b1);

    // Framing error followed by a long break
    f0 = ferr_count;
    send_frame(8'h3C, 1'b0, BIT);
    rx_n = 1'b0;
    repeat (8*BIT) @(posedge clk);
    #1;
    idle(2*BIT);
    check("ferr_single_pulse", ferr_count - f0, 1);
    check("ferr_no_ready", rx_ready_n, 1'b1);
    sb.push_back({8'h3C, 1'b1});
    send_frame(8'h3C, 1'b1, BIT);
    idle(BIT);
    read_pulse();

    // Read landing on the commit cycle with an older byte pending
    sb.push_back({8'h11, 1'b1});
    send_frame(8'h11, 1'b1, BIT);
    idle(BIT);
    sb.push_back({8'h7E, 1'b1});
    fork
      send_frame(8'h7E, 1'b1, BIT);
      begin
        repeat (HALF + 9*BIT + 2) @(posedge clk);
        #1 main_r_n = 1'b0;
        @(posedge clk);
        #1 main_r_n = 1'b1;
      end
    join
    idle(BIT);
    check("rdcommit_rx_data", rx_data, 8'h7E);
    check("rdcommit_ready_n", rx_ready_n, 1'b0);
    check("rdcommit_ovr_n", rx_ovr_n, 1'b1);
    read_pulse();

    // Reset mid-frame with a byte pending
    sb.push_back({8'h5A, 1'b1});
    send_frame(8'h5A, 1'b1, BIT);
    idle(BIT);
    f0 = ferr_count;
    fork
      send_frame(8'hFF, 1'b1, BIT);
      begin
        repeat (2 + HALF + 5*BIT - BIT/4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(2*BIT);
    check("midreset_no_ready", rx_ready_n, 1'b1);
    check("midreset_no_ferr", ferr_count - f0, 0);
    sb.push_back({8'h12, 1'b1});
    send_frame(8'h12, 1'b1, BIT);
    idle(BIT);
    check("after_reset_rx_data", rx_data, 8'h12);
    read_pulse();

    // Random traffic with skewed baud, glitches and framing errors
    auto_read = 1'b1;
    f0 = ferr_count;
    exp_ferr = 0;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      b = 8'($urandom);
      if (kind == 0) begin
        rx_n = 1'b0;
        repeat ($urandom_range(1, HALF - 4)) @(posedge clk);
        #1;
        idle(BIT);
      end else if (kind == 1) begin
        send_frame(b, 1'b0, BIT);
        rx_n = 1'b0;
        repeat ($urandom_range(1, 3*BIT)) @(posedge clk);
        #1;
        idle(BIT);
        exp_ferr++;
      end else begin
        sb.push_back({b, 1'b1});
        send_frame(b, 1'b1, BIT - 1 + int'($urandom_range(0, 2)));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, BIT));
      end
    end
    idle(2*BIT);
    auto_read = 1'b0;
    idle(BIT);
    check("random_ferr_count", ferr_count - f0, exp_ferr);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
